// File: rtl/sram_axi_bridge_if.sv
// ---------------------------------------------------------------------------
// sram_axi_bridge_if
//   Bundles the CPU SRAM-like request port and the AXI4 read/write channels
//   seen by sram_axi_bridge. AXI sideband fields (id, len, size, burst,
//   lock, cache, prot) are not carried; the instantiating top ties them off.
//
//   CPU side : req, wr, size, addr, wdata -> addr_ok, data_ok, rdata
//   AXI AR   : araddr, arvalid <- arready
//   AXI R    : axi_rdata, rvalid -> rready
//   AXI AW   : awaddr, awvalid <- awready
//   AXI W    : axi_wdata, wstrb, wvalid <- wready
//   AXI B    : bvalid -> bready
//
//   modport master : the bridge itself (it is the AXI master and serves the
//                    CPU request port)
//   modport slave  : the environment (CPU plus AXI memory)
// ---------------------------------------------------------------------------
interface sram_axi_bridge_if;
    // CPU request port
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    // AXI read address / data
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] axi_rdata;
    logic        rvalid;
    logic        rready;

    // AXI write address / data / response
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] axi_wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    modport master (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata,
        output araddr, arvalid,
        input  arready,
        input  axi_rdata, rvalid,
        output rready,
        output awaddr, awvalid,
        input  awready,
        output axi_wdata, wstrb, wvalid,
        input  wready,
        input  bvalid,
        output bready
    );

    modport slave (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata,
        input  araddr, arvalid,
        output arready,
        output axi_rdata, rvalid,
        input  rready,
        input  awaddr, awvalid,
        output awready,
        input  axi_wdata, wstrb, wvalid,
        output wready,
        output bvalid,
        input  bready
    );
endinterface

// File: rtl/sram_axi_bridge.sv
// ---------------------------------------------------------------------------
// sram_axi_bridge
//   Converts single CPU SRAM-like transactions into single-beat AXI4
//   transactions, one outstanding at a time.
//
//   clk : sole clock, all state on the rising edge
//   rst : asynchronous active-high reset
//   bus : sram_axi_bridge_if.master
//         - addr_ok is high whenever the bridge is idle (and not in reset);
//           req && addr_ok accepts a request and latches addr/wdata/strobes
//         - data_ok is a one-cycle pulse: read data valid (rdata passes
//           axi_rdata through) or write response received
//         - AXI addresses are the latched CPU address with bits [1:0] cleared
// ---------------------------------------------------------------------------
module sram_axi_bridge (
    input  logic              clk,
    input  logic              rst,
    sram_axi_bridge_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_AR,
        RD_R,
        WR_AW_W,
        WR_B
    } state_e;

    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;

    logic [31:0] addr_d;
    logic [3:0]  wstrb_d;
    logic        aw_done;
    logic        w_done;
    logic        aw_fin;
    logic        w_fin;

    // Byte strobes from access size and low address bits. Halfwords ignore
    // addr[0]; size 3 is treated as a full word.
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would infer a latch.
        wstrb_d = 4'b1111;
        case (bus.size)
            2'd0:    wstrb_d = 4'b0001 << bus.addr[1:0];
            2'd1:    wstrb_d = bus.addr[1] ? 4'b1100 : 4'b0011;
            default: wstrb_d = 4'b1111;
        endcase
    end

    assign addr_d = {bus.addr[31:2], 2'b00};

    // A channel is done once its valid has been dropped after the handshake;
    // *_fin also covers a handshake happening in the current cycle.
    assign aw_done = !awvalid_q;
    assign w_done  = !wvalid_q;
    assign aw_fin  = aw_done || bus.awready;
    assign w_fin   = w_done  || bus.wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the latched address/data/strobes are reset as well, so
            // the AXI address and data outputs read zero during reset.
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments only, so all
            // of them update together from the values of the previous cycle.
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        addr_q  <= addr_d;
                        wdata_q <= bus.wdata;
                        wstrb_q <= wstrb_d;
                        if (bus.wr) begin
                            state_q   <= WR_AW_W;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q   <= RD_AR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                RD_AR: begin
                    if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_R;
                    end
                end
                RD_R: begin
                    if (bus.rvalid) begin
                        rready_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                WR_AW_W: begin
                    if (bus.awready) awvalid_q <= 1'b0;
                    if (bus.wready)  wvalid_q  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_B;
                    end
                end
                WR_B: begin
                    if (bus.bvalid) begin
                        bready_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.addr_ok   = (state_q == IDLE) && !rst;
    // Ready is only high in RD_R / WR_B, so stray rvalid/bvalid are ignored.
    assign bus.data_ok   = (rready_q && bus.rvalid) || (bready_q && bus.bvalid);
    assign bus.rdata     = bus.axi_rdata;

    assign bus.araddr    = addr_q;
    assign bus.arvalid   = arvalid_q;
    assign bus.rready    = rready_q;
    assign bus.awaddr    = addr_q;
    assign bus.awvalid   = awvalid_q;
    assign bus.axi_wdata = wdata_q;
    assign bus.wstrb     = wstrb_q;
    assign bus.wvalid    = wvalid_q;
    assign bus.bready    = bready_q;

endmodule
